// File: rtl/imem_pkg.sv
`default_nettype none
// ============================================================================
// Module  : imem_pkg
// Brief   : Shared types and constants for the instruction-memory responder.
// Revision: 1.0 - initial release
// ============================================================================
package imem_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } imem_state_t;

  localparam logic [31:0] c_NOP             = 32'h0000_0000;
  localparam int          c_DEPTH_WORDS_DEF = 256;
  localparam int          c_LATENCY_DEF     = 3;

endpackage
`default_nettype wire

// File: rtl/imem_array.sv
`default_nettype none
// ============================================================================
// Module  : imem_array
// Brief   : Word storage, one sync write port and one sync read-before-write
//           read port. Only the read register is reset, never the contents.
// Revision: 1.0 - initial release
// ============================================================================
module imem_array
  import imem_pkg::*;
#(
  parameter int DEPTH_WORDS = c_DEPTH_WORDS_DEF,
  parameter int AW          = $clog2(DEPTH_WORDS)
) (
  input  logic          clk_i,
  input  logic          rst_i,
  input  logic          i_we,
  input  logic [AW-1:0] i_waddr,
  input  logic [31:0]   i_wdata,
  input  logic          i_re,
  input  logic [AW-1:0] i_raddr,
  output logic [31:0]   o_rdata
);

  logic [31:0] r_mem [DEPTH_WORDS];
  logic [31:0] r_rdata;

  always_ff @(posedge clk_i) begin
    if (i_we) begin
      r_mem[i_waddr] <= i_wdata;
    end
  end

  // Non-blocking read alongside the write gives old data on a same-word hit.
  always_ff @(posedge clk_i) begin
    if (!rst_i) begin
      r_rdata <= c_NOP;
    end else if (i_re) begin
      r_rdata <= r_mem[i_raddr];
    end
  end

  assign o_rdata = r_rdata;

endmodule
`default_nettype wire

// File: rtl/imem_responder.sv
`default_nettype none
// ============================================================================
// Module  : imem_responder
// Brief   : Fixed-latency instruction fetch responder with program-load port.
//           Optional IMEM_ADDR_CHECK_EN: NOP + err_o on misaligned/out-of-range.
// Revision: 1.0 - initial release
// ============================================================================
module imem_responder
  import imem_pkg::*;
#(
  parameter int DEPTH_WORDS = c_DEPTH_WORDS_DEF,
  parameter int LATENCY     = c_LATENCY_DEF
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        req_i,
  input  logic [31:0] addr_i,
  output logic        ready_o,
  output logic        valid_o,
  output logic [31:0] instr_o,
  output logic        bubble_o,
  output logic        err_o,
  input  logic        ld_we_i,
  input  logic [31:0] ld_addr_i,
  input  logic [31:0] ld_data_i
);

  localparam int         AW         = $clog2(DEPTH_WORDS);
  localparam logic [3:0] c_CNT_LOAD = (LATENCY > 1) ? 4'(LATENCY - 2) : 4'd0;
  localparam bit         c_DIRECT   = (LATENCY == 1);

  imem_state_t   r_state;
  imem_state_t   w_state_nxt;
  logic [3:0]    r_cnt;
  logic [3:0]    w_cnt_nxt;
  logic [AW-1:0] r_idx;
  logic          w_accept;
  logic          w_rd_en;
  logic          w_ld_we;
  logic [AW-1:0] w_fetch_idx;
  logic [AW-1:0] w_ld_idx;
  logic [AW-1:0] w_rd_idx;
  logic [31:0]   w_rdata;

  assign w_fetch_idx = addr_i[AW+1:2];
  assign w_ld_idx    = ld_addr_i[AW+1:2];

  assign ready_o  = (r_state != WAIT);
  assign valid_o  = (r_state == RESP);
  assign bubble_o = (r_state == WAIT);

  always_ff @(posedge clk_i) begin
    if (!rst_i) begin
      r_state <= IDLE;
      r_cnt   <= 4'd0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_accept    = 1'b0;
    w_rd_en     = 1'b0;
    case (r_state)
      IDLE, RESP: begin
        w_state_nxt = IDLE;
        if (req_i) begin
          w_accept = 1'b1;
          if (c_DIRECT) begin
            w_state_nxt = RESP;
            w_rd_en     = 1'b1;
          end else begin
            w_state_nxt = WAIT;
            w_cnt_nxt   = c_CNT_LOAD;
          end
        end
      end
      WAIT: begin
        if (r_cnt == 4'd0) begin
          w_state_nxt = RESP;
          w_rd_en     = 1'b1;
        end else begin
          w_cnt_nxt = r_cnt - 4'd1;
        end
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (!rst_i) begin
      r_idx <= '0;
    end else if (w_accept) begin
      r_idx <= w_fetch_idx;
    end
  end

  // With single-cycle latency the read happens on the acceptance edge itself.
  assign w_rd_idx = c_DIRECT ? w_fetch_idx : r_idx;

`ifdef IMEM_ADDR_CHECK_EN
  logic w_fetch_bad;
  logic w_ld_bad;
  logic r_bad;
  logic r_rsp_bad;

  assign w_fetch_bad = (addr_i[1:0] != 2'b00) || (addr_i[31:2] >= 30'(DEPTH_WORDS));
  assign w_ld_bad    = (ld_addr_i[1:0] != 2'b00) || (ld_addr_i[31:2] >= 30'(DEPTH_WORDS));
  assign w_ld_we     = ld_we_i & rst_i & ~w_ld_bad;

  always_ff @(posedge clk_i) begin
    if (!rst_i) begin
      r_bad     <= 1'b0;
      r_rsp_bad <= 1'b0;
    end else begin
      if (w_accept) begin
        r_bad <= w_fetch_bad;
      end
      if (w_rd_en) begin
        r_rsp_bad <= c_DIRECT ? w_fetch_bad : r_bad;
      end
    end
  end

  assign err_o   = valid_o & r_rsp_bad;
  assign instr_o = r_rsp_bad ? c_NOP : w_rdata;
`else
  logic w_unused_addr;

  assign w_unused_addr = ^{addr_i[31:AW+2], addr_i[1:0], ld_addr_i[31:AW+2], ld_addr_i[1:0]};
  assign w_ld_we       = ld_we_i & rst_i;
  assign err_o         = 1'b0;
  assign instr_o       = w_rdata;
`endif

  imem_array #(
    .DEPTH_WORDS (DEPTH_WORDS),
    .AW          (AW)
  ) u_array (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .i_we    (w_ld_we),
    .i_waddr (w_ld_idx),
    .i_wdata (ld_data_i),
    .i_re    (w_rd_en),
    .i_raddr (w_rd_idx),
    .o_rdata (w_rdata)
  );

endmodule
`default_nettype wire

// File: tb/tb_imem_responder.sv
`default_nettype none
// ============================================================================
// Module  : tb_imem_responder
// Brief   : Self-checking bench for imem_responder (LATENCY=3 and LATENCY=1).
// Revision: 1.0 - initial release
// ============================================================================
module tb_imem_responder;

  localparam int DEPTH = 256;

  typedef struct {
    logic [31:0] addr;
    logic [31:0] instr;
    logic        err;
  } vec_t;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        ld_we;
  logic [31:0] ld_addr;
  logic [31:0] ld_data;
  logic        req    [2];
  logic [31:0] addr   [2];
  logic        ready  [2];
  logic        valid  [2];
  logic        bubble [2];
  logic        err    [2];
  logic [31:0] instr  [2];

  int n_tests;
  int n_fail;
  int cyc;

  // Reference model state: memory image plus one outstanding fetch per DUT.
  logic [31:0] mem_m [DEPTH];
  bit          pend      [2];
  int          due       [2];
  logic [31:0] paddr     [2];
  logic [31:0] exp_instr [2];
  bit          exp_err   [2];

  vec_t vecs [6];

  always #5 clk = ~clk;

  imem_responder #(.DEPTH_WORDS(DEPTH), .LATENCY(3)) u0 (
    .clk_i(clk), .rst_i(rst_n), .req_i(req[0]), .addr_i(addr[0]),
    .ready_o(ready[0]), .valid_o(valid[0]), .instr_o(instr[0]),
    .bubble_o(bubble[0]), .err_o(err[0]),
    .ld_we_i(ld_we), .ld_addr_i(ld_addr), .ld_data_i(ld_data)
  );

  imem_responder #(.DEPTH_WORDS(DEPTH), .LATENCY(1)) u1 (
    .clk_i(clk), .rst_i(rst_n), .req_i(req[1]), .addr_i(addr[1]),
    .ready_o(ready[1]), .valid_o(valid[1]), .instr_o(instr[1]),
    .bubble_o(bubble[1]), .err_o(err[1]),
    .ld_we_i(ld_we), .ld_addr_i(ld_addr), .ld_data_i(ld_data)
  );

  function automatic logic [31:0] pat(input int i);
    return 32'h1000_0000 + 32'(i) * 32'h0001_0003;
  endfunction

  function automatic bit addr_bad(input logic [31:0] a);
`ifdef IMEM_ADDR_CHECK_EN
    return (a[1:0] != 2'b00) || ((a >> 2) >= 32'(DEPTH));
`else
    return (a === 32'hFFFF_FFFF) && 1'b0;
`endif
  endfunction

  function automatic int widx(input logic [31:0] a);
    return int'((a >> 2) % 32'(DEPTH));
  endfunction

  function automatic logic [31:0] rand_addr();
    logic [31:0] a;
    case ($urandom_range(0, 9))
      0:       a = 32'($urandom_range(0, 32'h7FF));
      1:       a = $urandom();
      default: a = 32'($urandom_range(0, DEPTH - 1)) << 2;
    endcase
    return a;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s @cyc %0d: got %h expected %h", name, cyc, act, exp);
    end
  endtask

  // Compare this cycle's outputs with the model, then advance one clock.
  task automatic tick(input bit do_chk);
    for (int d = 0; d < 2; d++) begin
      int lat;
      bit m_busy;
      bit m_valid;
      lat     = (d == 0) ? 3 : 1;
      m_busy  = pend[d] && (due[d] > cyc);
      m_valid = pend[d] && (due[d] == cyc);
      if (do_chk) begin
        chk($sformatf("u%0d valid", d),  32'(valid[d]),  32'(m_valid));
        chk($sformatf("u%0d ready", d),  32'(ready[d]),  32'(!m_busy));
        chk($sformatf("u%0d bubble", d), 32'(bubble[d]), 32'(m_busy));
        chk($sformatf("u%0d instr", d),  instr[d],       exp_instr[d]);
        chk($sformatf("u%0d err", d),    32'(err[d]),    32'(m_valid && exp_err[d]));
      end
      if (m_valid) pend[d] = 1'b0;
      if (req[d] && !m_busy) begin
        pend[d]  = 1'b1;
        due[d]   = cyc + lat;
        paddr[d] = addr[d];
      end
      if (pend[d] && (due[d] == cyc + 1)) begin
        exp_err[d]   = addr_bad(paddr[d]);
        exp_instr[d] = exp_err[d] ? 32'h0 : mem_m[widx(paddr[d])];
      end
      if (!rst_n) begin
        pend[d]      = 1'b0;
        exp_instr[d] = 32'h0;
        exp_err[d]   = 1'b0;
      end
    end
    if (rst_n && ld_we && !addr_bad(ld_addr)) mem_m[widx(ld_addr)] = ld_data;
    @(posedge clk);
    #1;
    cyc++;
  endtask

  initial begin
    n_tests = 0;
    n_fail  = 0;
    cyc     = 0;
    rst_n   = 1'b0;
    ld_we   = 1'b0;
    ld_addr = '0;
    ld_data = '0;
    for (int d = 0; d < 2; d++) begin
      req[d]       = 1'b0;
      addr[d]      = '0;
      pend[d]      = 1'b0;
      due[d]       = 0;
      paddr[d]     = '0;
      exp_instr[d] = '0;
      exp_err[d]   = 1'b0;
    end

    tick(1'b0);
    tick(1'b1);
    chk("rst valid",  32'(valid[0]),  32'd0);
    chk("rst bubble", 32'(bubble[0]), 32'd0);
    chk("rst err",    32'(err[0]),    32'd0);
    chk("rst ready",  32'(ready[0]),  32'd1);
    chk("rst instr",  instr[0],       32'h0);

    // Program load
    rst_n = 1'b1;
    for (int i = 0; i < DEPTH; i++) begin
      ld_we = 1'b1; ld_addr = 32'(i) << 2; ld_data = pat(i);
      tick(1'b1);
    end
    ld_addr = 32'h0; ld_data = 32'h2008_0005;
    tick(1'b1);
    ld_we = 1'b0;
    rst_n = 1'b0;
    tick(1'b1);
    rst_n = 1'b1;

    // Single fetch, LATENCY=3
    req[0] = 1'b1; addr[0] = 32'h0;
    tick(1'b1);
    req[0] = 1'b0;
    chk("lat3 bubble c1", 32'(bubble[0]), 32'd1);
    chk("lat3 ready c1",  32'(ready[0]),  32'd0);
    tick(1'b1);
    chk("lat3 bubble c2", 32'(bubble[0]), 32'd1);
    chk("lat3 valid c2",  32'(valid[0]),  32'd0);
    tick(1'b1);
    chk("lat3 valid c3",  32'(valid[0]),  32'd1);
    chk("lat3 instr c3",  instr[0],       32'h2008_0005);
    chk("lat3 bubble c3", 32'(bubble[0]), 32'd0);
    tick(1'b1);
    chk("lat3 idle valid", 32'(valid[0]), 32'd0);
    chk("lat3 idle ready", 32'(ready[0]), 32'd1);
    chk("lat3 hold instr", instr[0],      32'h2008_0005);

    // Address vector table on both latencies
    vecs[0] = '{32'h0000_0004, pat(1),   1'b0};
    vecs[1] = '{32'h0000_03FC, pat(255), 1'b0};
    vecs[2] = '{32'h0000_0010, pat(4),   1'b0};
`ifdef IMEM_ADDR_CHECK_EN
    vecs[3] = '{32'h0000_0002, 32'h0, 1'b1};
    vecs[4] = '{32'h0000_0400, 32'h0, 1'b1};
    vecs[5] = '{32'h0000_0406, 32'h0, 1'b1};
`else
    vecs[3] = '{32'h0000_0002, 32'h2008_0005, 1'b0};
    vecs[4] = '{32'h0000_0400, 32'h2008_0005, 1'b0};
    vecs[5] = '{32'h0000_0406, pat(1),        1'b0};
`endif
    for (int k = 0; k < 6; k++) begin
      req[0] = 1'b1; req[1] = 1'b1;
      addr[0] = vecs[k].addr; addr[1] = vecs[k].addr;
      tick(1'b1);
      req[0] = 1'b0; req[1] = 1'b0;
      chk($sformatf("vec%0d u1 valid", k), 32'(valid[1]), 32'd1);
      chk($sformatf("vec%0d u1 instr", k), instr[1],      vecs[k].instr);
      chk($sformatf("vec%0d u1 err", k),   32'(err[1]),   32'(vecs[k].err));
      tick(1'b1);
      tick(1'b1);
      chk($sformatf("vec%0d u0 valid", k), 32'(valid[0]), 32'd1);
      chk($sformatf("vec%0d u0 instr", k), instr[0],      vecs[k].instr);
      chk($sformatf("vec%0d u0 err", k),   32'(err[0]),   32'(vecs[k].err));
      tick(1'b1);
    end

    // Back-to-back, LATENCY=1
    req[1] = 1'b1;
    for (int k = 0; k < 4; k++) begin
      addr[1] = 32'(k) << 2;
      tick(1'b1);
      chk($sformatf("b2b%0d valid", k),  32'(valid[1]),  32'd1);
      chk($sformatf("b2b%0d instr", k),  instr[1],       (k == 0) ? 32'h2008_0005 : pat(k));
      chk($sformatf("b2b%0d bubble", k), 32'(bubble[1]), 32'd0);
    end
    req[1] = 1'b0;
    tick(1'b1);

    // Load to the same word on the edge entering RESP
    req[0] = 1'b1; addr[0] = 32'h8;
    tick(1'b1);
    req[0] = 1'b0;
    tick(1'b1);
    ld_we = 1'b1; ld_addr = 32'h8; ld_data = 32'hDEAD_BEEF;
    tick(1'b1);
    ld_we = 1'b0;
    chk("rbw old valid", 32'(valid[0]), 32'd1);
    chk("rbw old instr", instr[0],      pat(2));
    tick(1'b1);
    req[0] = 1'b1; addr[0] = 32'h8;
    tick(1'b1);
    req[0] = 1'b0;
    tick(1'b1);
    tick(1'b1);
    chk("rbw new instr", instr[0], 32'hDEAD_BEEF);
    tick(1'b1);

    // Reset during WAIT drops the fetch; loads during reset are ignored
    req[0] = 1'b1; addr[0] = 32'h10;
    tick(1'b1);
    req[0] = 1'b0;
    chk("rstwait in wait", 32'(bubble[0]), 32'd1);
    rst_n = 1'b0; ld_we = 1'b1; ld_addr = 32'h1C; ld_data = 32'hBADB_AD00;
    tick(1'b1);
    rst_n = 1'b1; ld_we = 1'b0;
    for (int k = 0; k < 4; k++) begin
      chk($sformatf("rstwait%0d valid", k), 32'(valid[0]), 32'd0);
      chk($sformatf("rstwait%0d ready", k), 32'(ready[0]), 32'd1);
      tick(1'b1);
    end
    req[0] = 1'b1; addr[0] = 32'h1C;
    tick(1'b1);
    req[0] = 1'b0;
    tick(1'b1);
    tick(1'b1);
    chk("rst ld ignored", instr[0], pat(7));
    tick(1'b1);

    // Randomized traffic against the model
    for (int n = 0; n < 4000; n++) begin
      for (int d = 0; d < 2; d++) begin
        req[d]  = ($urandom_range(0, 9) < 6);
        addr[d] = rand_addr();
      end
      ld_we   = ($urandom_range(0, 3) == 0);
      ld_addr = rand_addr();
      ld_data = $urandom();
      rst_n   = ($urandom_range(0, 149) != 0);
      tick(1'b1);
    end
    req[0] = 1'b0; req[1] = 1'b0; ld_we = 1'b0; rst_n = 1'b1;
    for (int n = 0; n < 5; n++) tick(1'b1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
